slc3_ctrl_gen: RTL and testbench
================================

SLC3_CTRL_GEN -- requirements
Module: slc3_ctrl_gen

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 3: number of memory wait cycles per read or write (1..15).
REQ-002 SHALL have parameter NREG, default 8: register file depth; legal values are 2..8.
REQ-003 SHALL have parameter RW, default 3: register index width, equal to clog2(NREG).
REQ-004 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port ir, input, 16 bits: instruction register contents.
REQ-007 SHALL have port nzp, input, 3 bits: condition codes.
REQ-008 SHALL have ports run_i and continue_i, inputs, 1 bit each: start and pause-release controls.
REQ-009 SHALL have outputs ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_ben, ld_cc, 1 bit each: register load strobes.
REQ-010 SHALL have output ld_reg, NREG bits: one-hot destination register load.
REQ-011 SHALL have outputs gate_pc, gate_mdr, gate_marmux, gate_alu, 1 bit each: bus drivers.
REQ-012 SHALL have output pcmux, 2 bits: 00 = PC+1, 01 = adder, 10 = bus.
REQ-013 SHALL have output addr2mux, 2 bits: 00 = 0, 01 = off9, 10 = off6, 11 = off11.
REQ-014 SHALL have output addr1mux, 1 bit: 0 = SR1, 1 = PC.
REQ-015 SHALL have outputs sr1_select and sr2_select, RW bits each: register read indices.
REQ-016 SHALL have output sr2mux, 1 bit: 1 = register, 0 = imm5.
REQ-017 SHALL have output alu_select, 2 bits: 00 = ADD, 01 = AND, 10 = NOT, 11 = PASS A.
REQ-018 SHALL have output mio_en, 1 bit: 1 = MDR loads from bus, 0 = MDR loads from memory.
REQ-019 SHALL have outputs mem_ena and mem_wr, 1 bit each: memory enable and write enable.
REQ-020 SHALL have output illegal_o, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-021 SHALL implement a Moore FSM with states HALT, F_MAR, F_WAIT, F_IR, DECODE, ADD, AND, NOT, BR, BR_TAKE, JMP, JSR_SAVE, JSR_JUMP, LD_ADDR, LD_WAIT, LD_WB, ST_ADDR, ST_DATA, ST_WAIT, PAUSE1, PAUSE2.
REQ-022 SHALL hold every output at 0 in any state unless this document states otherwise.
REQ-023 SHALL leave HALT to F_MAR when run_i=1, and otherwise stay in HALT.
REQ-024 SHALL, in F_MAR, assert gate_pc, ld_mar and ld_pc with pcmux=00, then go to F_WAIT.
REQ-025 SHALL use a 4-bit wait counter shared by F_WAIT, LD_WAIT and ST_WAIT.
- Counter is loaded with MEM_WAIT-1 on entry to the wait state.
- State is held until the counter reaches 0, giving exactly MEM_WAIT cycles.
REQ-026 SHALL, in F_WAIT and LD_WAIT, assert mem_ena and ld_mdr with mio_en=0.
REQ-027 SHALL, in ST_WAIT, assert mem_ena and mem_wr.
REQ-028 SHALL, in F_IR, assert gate_mdr and ld_ir, then go to DECODE.
REQ-029 SHALL, in DECODE, assert ld_ben and dispatch on ir[15:12].
- 0001 -> ADD, 0101 -> AND, 1001 -> NOT, 0000 -> BR, 1100 -> JMP.
- 0100 -> JSR_SAVE, 0110 -> LD_ADDR, 0111 -> ST_ADDR, 1101 -> PAUSE1.
- Any other opcode -> F_MAR, with illegal_o=1 for that cycle.
REQ-030 SHALL, in ADD and AND, drive the following, then go to F_MAR.
- sr1_select=ir[8:6]; sr2mux=~ir[5]; sr2_select=ir[2:0].
- gate_alu and ld_cc asserted; ld_reg one-hot on ir[11:9].
REQ-031 SHALL, in NOT, drive alu_select=10, sr1_select=ir[8:6], gate_alu, ld_cc and ld_reg[ir[11:9]], then go to F_MAR.
REQ-032 SHALL, in BR, compute ben = |(ir[11:9] & nzp) combinationally and go to BR_TAKE if ben=1, else to F_MAR.
REQ-033 SHALL, in BR_TAKE, drive addr1mux=1, addr2mux=01, pcmux=01 and ld_pc, then go to F_MAR.
REQ-034 SHALL, in JMP, drive sr1_select=ir[8:6], alu_select=11, gate_alu, pcmux=10 and ld_pc, then go to F_MAR.
REQ-035 SHALL, in JSR_SAVE, assert gate_pc and ld_reg[NREG-1], then go to JSR_JUMP.
REQ-036 SHALL, in JSR_JUMP, assert ld_pc and pcmux=01, with address selection by ir[11], then go to F_MAR.
- ir[11]=1: addr1mux=1, addr2mux=11.
- ir[11]=0: addr1mux=0, addr2mux=00, sr1_select=ir[8:6].
REQ-037 SHALL, in LD_ADDR and ST_ADDR, drive sr1_select=ir[8:6], addr1mux=0, addr2mux=10, gate_marmux and ld_mar.
- LD_ADDR -> LD_WAIT; ST_ADDR -> ST_DATA.
REQ-038 SHALL, in LD_WB, assert gate_mdr, ld_cc and ld_reg[ir[11:9]], then go to F_MAR.
REQ-039 SHALL, in ST_DATA, drive sr1_select=ir[11:9], alu_select=11, gate_alu, mio_en=1 and ld_mdr, then go to ST_WAIT.
REQ-040 SHALL go from ST_WAIT to F_MAR and from LD_WAIT to LD_WB when the wait count expires.
REQ-041 SHALL, in PAUSE1 and PAUSE2, assert ld_led.
- PAUSE1 -> PAUSE2 when continue_i=1.
- PAUSE2 -> F_MAR when continue_i=0.
REQ-042 SHALL, for register indices with value >= NREG, leave all ld_reg bits at 0 and raise illegal_o for one cycle in the writeback state.
REQ-043 SHALL never assert more than one ld_reg bit, and never assert more than one gate_* signal, in the same cycle.

Reset
REQ-044 SHALL, when reset=1 at a clock edge in any state (including during wait states), enter HALT, clear the wait counter, and drive all outputs to 0 on the next cycle.
REQ-045 SHALL give reset priority over run_i and continue_i.

Verification
REQ-046 SHALL cover this fetch case: MEM_WAIT=3, run_i=1 from HALT -> F_MAR, then 3 cycles with mem_ena=1, then F_IR with ld_ir=1, then DECODE, over 6 cycles total.
REQ-047 SHALL cover this ADD case: ir=0x1283 (R1 = R2 + R3) -> sr1_select=2, sr2_select=3, sr2mux=1, ld_reg=0x02, ld_cc=1.
REQ-048 SHALL cover this branch case: ir=0x0405 (BRz) with nzp=010 -> BR_TAKE with pcmux=01; the same ir with nzp=100 -> F_MAR, and ld_pc stays 0 in BR.
REQ-049 SHALL cover this JSR case: ir=0x4800 -> ld_reg[7]=1 in JSR_SAVE, then addr2mux=11 in JSR_JUMP.
REQ-050 SHALL cover this store case: MEM_WAIT=5, ir=0x7642 -> mem_wr=1 for exactly 5 cycles; a reset asserted in wait cycle 2 -> HALT with mem_wr=0 on the next cycle.
REQ-051 SHALL cover this edge case: NREG=4, ir=0x1E01 (DR=7) -> ld_reg=0 and illegal_o pulses once; ir=0xF000 -> illegal_o=1 in DECODE, then F_MAR.

Source files
------------

// File: rtl/slc3_ctrl_gen.sv
// SLC-3 control unit: Moore FSM sequencing fetch, decode and execute for the
// LC-3 subset, with a shared memory wait counter and registered control outputs.
module slc3_ctrl_gen #(
    parameter int MEM_WAIT = 3,
    parameter int NREG     = 8,
    parameter int RW       = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     ir,
    input  logic [2:0]      nzp,
    input  logic            run_i,
    input  logic            continue_i,
    output logic            ld_mar,
    output logic            ld_mdr,
    output logic            ld_ir,
    output logic            ld_pc,
    output logic            ld_led,
    output logic            ld_ben,
    output logic            ld_cc,
    output logic [NREG-1:0] ld_reg,
    output logic            gate_pc,
    output logic            gate_mdr,
    output logic            gate_marmux,
    output logic            gate_alu,
    output logic [1:0]      pcmux,
    output logic [1:0]      addr2mux,
    output logic            addr1mux,
    output logic [RW-1:0]   sr1_select,
    output logic [RW-1:0]   sr2_select,
    output logic            sr2mux,
    output logic [1:0]      alu_select,
    output logic            mio_en,
    output logic            mem_ena,
    output logic            mem_wr,
    output logic            illegal_o
);

    typedef enum logic [4:0] {
        HALT, F_MAR, F_WAIT, F_IR, DECODE,
        S_ADD, S_AND, S_NOT, BR, BR_TAKE, JMP,
        JSR_SAVE, JSR_JUMP, LD_ADDR, LD_WAIT, LD_WB,
        ST_ADDR, ST_DATA, ST_WAIT, PAUSE1, PAUSE2
    } state_t;

    typedef struct packed {
        logic            ld_mar;
        logic            ld_mdr;
        logic            ld_ir;
        logic            ld_pc;
        logic            ld_led;
        logic            ld_ben;
        logic            ld_cc;
        logic [NREG-1:0] ld_reg;
        logic            gate_pc;
        logic            gate_mdr;
        logic            gate_marmux;
        logic            gate_alu;
        logic [1:0]      pcmux;
        logic [1:0]      addr2mux;
        logic            addr1mux;
        logic [RW-1:0]   sr1_select;
        logic [RW-1:0]   sr2_select;
        logic            sr2mux;
        logic [1:0]      alu_select;
        logic            mio_en;
        logic            mem_ena;
        logic            mem_wr;
        logic            ill;
    } ctrl_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    ctrl_t           ctl, ctl_nx;
    logic [3:0]      op;
    logic            op_ok;
    logic            ben;
    logic            dr_ok;
    logic [NREG-1:0] dr_hot;
    logic [RW-1:0]   sr_a, sr_b, sr_dr;
    logic            unused_ir;

    assign op        = ir[15:12];
    assign ben       = |(ir[11:9] & nzp);
    assign sr_a      = ir[6 +: RW];
    assign sr_b      = ir[0 +: RW];
    assign sr_dr     = ir[9 +: RW];
    assign dr_ok     = int'(ir[11:9]) < NREG;
    assign unused_ir = ^ir[4:3];

    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_BR, OP_ADD, OP_JSR, OP_AND, OP_LDR,
            OP_STR, OP_NOT, OP_JMP, OP_PSE: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
    end

    // Destination indices past the register file select nothing.
    always_comb begin
        dr_hot = '0;
        if (dr_ok) dr_hot[ir[9 +: RW]] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            HALT:     if (run_i) state_nx = F_MAR;
            F_MAR:    begin state_nx = F_WAIT; cnt_nx = WAIT_LOAD; end
            F_WAIT:   if (cnt == 4'd0) state_nx = F_IR; else cnt_nx = cnt - 4'd1;
            F_IR:     state_nx = DECODE;
            DECODE: begin
                case (op)
                    OP_ADD:  state_nx = S_ADD;
                    OP_AND:  state_nx = S_AND;
                    OP_NOT:  state_nx = S_NOT;
                    OP_BR:   state_nx = BR;
                    OP_JMP:  state_nx = JMP;
                    OP_JSR:  state_nx = JSR_SAVE;
                    OP_LDR:  state_nx = LD_ADDR;
                    OP_STR:  state_nx = ST_ADDR;
                    OP_PSE:  state_nx = PAUSE1;
                    default: state_nx = F_MAR;
                endcase
            end
            S_ADD, S_AND, S_NOT, BR_TAKE, JMP, JSR_JUMP, LD_WB:
                      state_nx = F_MAR;
            BR:       state_nx = ben ? BR_TAKE : F_MAR;
            JSR_SAVE: state_nx = JSR_JUMP;
            LD_ADDR:  begin state_nx = LD_WAIT; cnt_nx = WAIT_LOAD; end
            LD_WAIT:  if (cnt == 4'd0) state_nx = LD_WB; else cnt_nx = cnt - 4'd1;
            ST_ADDR:  state_nx = ST_DATA;
            ST_DATA:  begin state_nx = ST_WAIT; cnt_nx = WAIT_LOAD; end
            ST_WAIT:  if (cnt == 4'd0) state_nx = F_MAR; else cnt_nx = cnt - 4'd1;
            PAUSE1:   if (continue_i) state_nx = PAUSE2;
            PAUSE2:   if (!continue_i) state_nx = F_MAR;
            default:  state_nx = HALT;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ctl_nx = '0;
        case (state_nx)
            F_MAR: begin
                ctl_nx.gate_pc = 1'b1;
                ctl_nx.ld_mar  = 1'b1;
                ctl_nx.ld_pc   = 1'b1;
            end
            F_WAIT, LD_WAIT: begin
                ctl_nx.mem_ena = 1'b1;
                ctl_nx.ld_mdr  = 1'b1;
            end
            ST_WAIT: begin
                ctl_nx.mem_ena = 1'b1;
                ctl_nx.mem_wr  = 1'b1;
            end
            F_IR: begin
                ctl_nx.gate_mdr = 1'b1;
                ctl_nx.ld_ir    = 1'b1;
            end
            DECODE: ctl_nx.ld_ben = 1'b1;
            S_ADD, S_AND: begin
                ctl_nx.sr1_select = sr_a;
                ctl_nx.sr2_select = sr_b;
                ctl_nx.sr2mux     = ~ir[5];
                ctl_nx.alu_select = (state_nx == S_AND) ? 2'b01 : 2'b00;
                ctl_nx.gate_alu   = 1'b1;
                ctl_nx.ld_cc      = 1'b1;
                ctl_nx.ld_reg     = dr_hot;
                ctl_nx.ill        = ~dr_ok;
            end
            S_NOT: begin
                ctl_nx.sr1_select = sr_a;
                ctl_nx.alu_select = 2'b10;
                ctl_nx.gate_alu   = 1'b1;
                ctl_nx.ld_cc      = 1'b1;
                ctl_nx.ld_reg     = dr_hot;
                ctl_nx.ill        = ~dr_ok;
            end
            BR_TAKE: begin
                ctl_nx.addr1mux = 1'b1;
                ctl_nx.addr2mux = 2'b01;
                ctl_nx.pcmux    = 2'b01;
                ctl_nx.ld_pc    = 1'b1;
            end
            JMP: begin
                ctl_nx.sr1_select = sr_a;
                ctl_nx.alu_select = 2'b11;
                ctl_nx.gate_alu   = 1'b1;
                ctl_nx.pcmux      = 2'b10;
                ctl_nx.ld_pc      = 1'b1;
            end
            JSR_SAVE: begin
                ctl_nx.gate_pc          = 1'b1;
                ctl_nx.ld_reg[NREG-1]   = 1'b1;
            end
            JSR_JUMP: begin
                ctl_nx.ld_pc = 1'b1;
                ctl_nx.pcmux = 2'b01;
                if (ir[11]) begin
                    ctl_nx.addr1mux = 1'b1;
                    ctl_nx.addr2mux = 2'b11;
                end else begin
                    ctl_nx.sr1_select = sr_a;
                end
            end
            LD_ADDR, ST_ADDR: begin
                ctl_nx.sr1_select  = sr_a;
                ctl_nx.addr2mux    = 2'b10;
                ctl_nx.gate_marmux = 1'b1;
                ctl_nx.ld_mar      = 1'b1;
            end
            LD_WB: begin
                ctl_nx.gate_mdr = 1'b1;
                ctl_nx.ld_cc    = 1'b1;
                ctl_nx.ld_reg   = dr_hot;
                ctl_nx.ill      = ~dr_ok;
            end
            ST_DATA: begin
                ctl_nx.sr1_select = sr_dr;
                ctl_nx.alu_select = 2'b11;
                ctl_nx.gate_alu   = 1'b1;
                ctl_nx.mio_en     = 1'b1;
                ctl_nx.ld_mdr     = 1'b1;
            end
            PAUSE1, PAUSE2: ctl_nx.ld_led = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HALT;
            cnt   <= '0;
            ctl   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ctl   <= ctl_nx;
        end
    end

    assign ld_mar      = ctl.ld_mar;
    assign ld_mdr      = ctl.ld_mdr;
    assign ld_ir       = ctl.ld_ir;
    assign ld_pc       = ctl.ld_pc;
    assign ld_led      = ctl.ld_led;
    assign ld_ben      = ctl.ld_ben;
    assign ld_cc       = ctl.ld_cc;
    assign ld_reg      = ctl.ld_reg;
    assign gate_pc     = ctl.gate_pc;
    assign gate_mdr    = ctl.gate_mdr;
    assign gate_marmux = ctl.gate_marmux;
    assign gate_alu    = ctl.gate_alu;
    assign pcmux       = ctl.pcmux;
    assign addr2mux    = ctl.addr2mux;
    assign addr1mux    = ctl.addr1mux;
    assign sr1_select  = ctl.sr1_select;
    assign sr2_select  = ctl.sr2_select;
    assign sr2mux      = ctl.sr2mux;
    assign alu_select  = ctl.alu_select;
    assign mio_en      = ctl.mio_en;
    assign mem_ena     = ctl.mem_ena;
    assign mem_wr      = ctl.mem_wr;
    // The opcode is only valid once IR has loaded, so the DECODE flag looks at live ir.
    assign illegal_o   = ctl.ill | ((state == DECODE) & ~op_ok);

endmodule

// File: tb/tb_slc3_ctrl_gen.sv
// Bench for slc3_ctrl_gen: instance A uses default parameters, instance B uses
// MEM_WAIT=5 / NREG=4; both share stimulus, each test checks its target instance.
module tb_slc3_ctrl_gen;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_led, ld_ben, ld_cc;
        logic [7:0] ld_reg;
        logic       gate_pc, gate_mdr, gate_marmux, gate_alu;
        logic [1:0] pcmux, addr2mux;
        logic       addr1mux;
        logic [2:0] sr1, sr2;
        logic       sr2mux;
        logic [1:0] alu;
        logic       mio_en, mem_ena, mem_wr, illegal;
    } obs_t;

    logic        clk, reset, run_i, continue_i;
    logic [15:0] ir;
    logic [2:0]  nzp;

    logic       a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_pc, a_ld_led, a_ld_ben, a_ld_cc;
    logic [7:0] a_ld_reg;
    logic       a_gate_pc, a_gate_mdr, a_gate_marmux, a_gate_alu;
    logic [1:0] a_pcmux, a_addr2mux, a_alu;
    logic       a_addr1mux, a_sr2mux, a_mio_en, a_mem_ena, a_mem_wr, a_illegal;
    logic [2:0] a_sr1, a_sr2;

    logic       b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_pc, b_ld_led, b_ld_ben, b_ld_cc;
    logic [3:0] b_ld_reg;
    logic       b_gate_pc, b_gate_mdr, b_gate_marmux, b_gate_alu;
    logic [1:0] b_pcmux, b_addr2mux, b_alu;
    logic       b_addr1mux, b_sr2mux, b_mio_en, b_mem_ena, b_mem_wr, b_illegal;
    logic [1:0] b_sr1, b_sr2;

    int   n_chk = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    slc3_ctrl_gen u_a (
        .clk(clk), .reset(reset), .ir(ir), .nzp(nzp), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(a_ld_mar), .ld_mdr(a_ld_mdr), .ld_ir(a_ld_ir), .ld_pc(a_ld_pc),
        .ld_led(a_ld_led), .ld_ben(a_ld_ben), .ld_cc(a_ld_cc), .ld_reg(a_ld_reg),
        .gate_pc(a_gate_pc), .gate_mdr(a_gate_mdr), .gate_marmux(a_gate_marmux),
        .gate_alu(a_gate_alu), .pcmux(a_pcmux), .addr2mux(a_addr2mux), .addr1mux(a_addr1mux),
        .sr1_select(a_sr1), .sr2_select(a_sr2), .sr2mux(a_sr2mux), .alu_select(a_alu),
        .mio_en(a_mio_en), .mem_ena(a_mem_ena), .mem_wr(a_mem_wr), .illegal_o(a_illegal)
    );

    slc3_ctrl_gen #(.MEM_WAIT(5), .NREG(4), .RW(2)) u_b (
        .clk(clk), .reset(reset), .ir(ir), .nzp(nzp), .run_i(run_i), .continue_i(continue_i),
        .ld_mar(b_ld_mar), .ld_mdr(b_ld_mdr), .ld_ir(b_ld_ir), .ld_pc(b_ld_pc),
        .ld_led(b_ld_led), .ld_ben(b_ld_ben), .ld_cc(b_ld_cc), .ld_reg(b_ld_reg),
        .gate_pc(b_gate_pc), .gate_mdr(b_gate_mdr), .gate_marmux(b_gate_marmux),
        .gate_alu(b_gate_alu), .pcmux(b_pcmux), .addr2mux(b_addr2mux), .addr1mux(b_addr1mux),
        .sr1_select(b_sr1), .sr2_select(b_sr2), .sr2mux(b_sr2mux), .alu_select(b_alu),
        .mio_en(b_mio_en), .mem_ena(b_mem_ena), .mem_wr(b_mem_wr), .illegal_o(b_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs_a();
        obs_t o;
        o = '0;
        o.ld_mar = a_ld_mar; o.ld_mdr = a_ld_mdr; o.ld_ir = a_ld_ir; o.ld_pc = a_ld_pc;
        o.ld_led = a_ld_led; o.ld_ben = a_ld_ben; o.ld_cc = a_ld_cc; o.ld_reg = a_ld_reg;
        o.gate_pc = a_gate_pc; o.gate_mdr = a_gate_mdr; o.gate_marmux = a_gate_marmux;
        o.gate_alu = a_gate_alu; o.pcmux = a_pcmux; o.addr2mux = a_addr2mux;
        o.addr1mux = a_addr1mux; o.sr1 = a_sr1; o.sr2 = a_sr2; o.sr2mux = a_sr2mux;
        o.alu = a_alu; o.mio_en = a_mio_en; o.mem_ena = a_mem_ena; o.mem_wr = a_mem_wr;
        o.illegal = a_illegal;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '0;
        o.ld_mar = b_ld_mar; o.ld_mdr = b_ld_mdr; o.ld_ir = b_ld_ir; o.ld_pc = b_ld_pc;
        o.ld_led = b_ld_led; o.ld_ben = b_ld_ben; o.ld_cc = b_ld_cc; o.ld_reg = {4'b0, b_ld_reg};
        o.gate_pc = b_gate_pc; o.gate_mdr = b_gate_mdr; o.gate_marmux = b_gate_marmux;
        o.gate_alu = b_gate_alu; o.pcmux = b_pcmux; o.addr2mux = b_addr2mux;
        o.addr1mux = b_addr1mux; o.sr1 = {1'b0, b_sr1}; o.sr2 = {1'b0, b_sr2};
        o.sr2mux = b_sr2mux; o.alu = b_alu; o.mio_en = b_mio_en; o.mem_ena = b_mem_ena;
        o.mem_wr = b_mem_wr; o.illegal = b_illegal;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; run_i = 1'b0; continue_i = 1'b0;
        skip(2);
        reset = 1'b0;
    endtask

    // After this returns both instances sit in their first F_MAR cycle.
    task automatic start(input logic [15:0] iv, input logic [2:0] nv);
        ir = iv; nzp = nv; run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    // Expected per-cycle outputs for one instruction, from the first fetch cycle
    // through the fetch cycle of the following instruction.
    task automatic model(input logic [15:0] iv, input logic [2:0] nv, input int mw, input int nreg);
        obs_t e;
        logic [3:0] op;
        logic [2:0] m, dr;
        logic       dr_ok;
        logic [7:0] dr_hot;
        op     = iv[15:12];
        m      = 3'(nreg - 1);
        dr     = iv[11:9];
        dr_ok  = int'(dr) < nreg;
        dr_hot = dr_ok ? 8'(1 << dr) : 8'h00;
        exp_q.delete();
        e = '0; e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; exp_q.push_back(e);
        for (int i = 0; i < mw; i++) begin e = '0; e.mem_ena = 1; e.ld_mdr = 1; exp_q.push_back(e); end
        e = '0; e.gate_mdr = 1; e.ld_ir = 1; exp_q.push_back(e);
        e = '0; e.ld_ben = 1;
        e.illegal = !(op inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hC, 4'hD});
        exp_q.push_back(e);
        case (op)
            4'h1, 4'h5: begin
                e = '0; e.sr1 = iv[8:6] & m; e.sr2 = iv[2:0] & m; e.sr2mux = !iv[5];
                e.alu = (op == 4'h5) ? 2'b01 : 2'b00; e.gate_alu = 1; e.ld_cc = 1;
                e.ld_reg = dr_hot; e.illegal = !dr_ok; exp_q.push_back(e);
            end
            4'h9: begin
                e = '0; e.sr1 = iv[8:6] & m; e.alu = 2'b10; e.gate_alu = 1; e.ld_cc = 1;
                e.ld_reg = dr_hot; e.illegal = !dr_ok; exp_q.push_back(e);
            end
            4'h0: begin
                e = '0; exp_q.push_back(e);
                if (|(iv[11:9] & nv)) begin
                    e.addr1mux = 1; e.addr2mux = 2'b01; e.pcmux = 2'b01; e.ld_pc = 1;
                    exp_q.push_back(e);
                end
            end
            4'hC: begin
                e = '0; e.sr1 = iv[8:6] & m; e.alu = 2'b11; e.gate_alu = 1; e.pcmux = 2'b10;
                e.ld_pc = 1; exp_q.push_back(e);
            end
            4'h4: begin
                e = '0; e.gate_pc = 1; e.ld_reg = 8'(1 << (nreg - 1)); exp_q.push_back(e);
                e = '0; e.ld_pc = 1; e.pcmux = 2'b01;
                if (iv[11]) begin e.addr1mux = 1; e.addr2mux = 2'b11; end
                else e.sr1 = iv[8:6] & m;
                exp_q.push_back(e);
            end
            4'h6, 4'h7: begin
                e = '0; e.sr1 = iv[8:6] & m; e.addr2mux = 2'b10; e.gate_marmux = 1; e.ld_mar = 1;
                exp_q.push_back(e);
                if (op == 4'h6) begin
                    for (int i = 0; i < mw; i++) begin e = '0; e.mem_ena = 1; e.ld_mdr = 1; exp_q.push_back(e); end
                    e = '0; e.gate_mdr = 1; e.ld_cc = 1; e.ld_reg = dr_hot; e.illegal = !dr_ok;
                    exp_q.push_back(e);
                end else begin
                    e = '0; e.sr1 = iv[11:9] & m; e.alu = 2'b11; e.gate_alu = 1; e.mio_en = 1;
                    e.ld_mdr = 1; exp_q.push_back(e);
                    for (int i = 0; i < mw; i++) begin e = '0; e.mem_ena = 1; e.mem_wr = 1; exp_q.push_back(e); end
                end
            end
            default: ;
        endcase
        e = '0; e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; exp_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t z;
        z = '0;
        do_reset();
        n_chk++;
        if (obs_a() !== z) begin n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a(), z); end
        n_chk++;
        if (obs_b() !== z) begin n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b(), z); end
        ir = 16'h1283; skip(3);
        n_chk++;
        if (obs_a() !== z) begin n_fail++; $display("FAIL halt_idle: got %h expected %h", obs_a(), z); end
        reset = 1'b1; run_i = 1'b1; continue_i = 1'b1;
        skip(2);
        n_chk++;
        if (obs_a() !== z) begin n_fail++; $display("FAIL reset_prio: got %h expected %h", obs_a(), z); end
        reset = 1'b0; run_i = 1'b0; continue_i = 1'b0;
    endtask

    task automatic test_fetch_add();
        obs_t e;
        do_reset();
        start(16'h1283, 3'b000);
        e = '0; e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL fetch_mar: got %h expected %h", obs_a(), e); end
        for (int i = 0; i < 3; i++) begin
            tick();
            e = '0; e.mem_ena = 1; e.ld_mdr = 1;
            n_chk++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL fetch_wait%0d: got %h expected %h", i, obs_a(), e); end
        end
        tick();
        e = '0; e.gate_mdr = 1; e.ld_ir = 1;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL fetch_ir: got %h expected %h", obs_a(), e); end
        tick();
        e = '0; e.ld_ben = 1;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL decode: got %h expected %h", obs_a(), e); end
        tick();
        e = '0; e.sr1 = 3'd2; e.sr2 = 3'd3; e.sr2mux = 1; e.ld_reg = 8'h02; e.ld_cc = 1; e.gate_alu = 1;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL add_exec: got %h expected %h", obs_a(), e); end
        tick();
        n_chk++;
        if ({a_gate_pc, a_ld_mar, a_ld_reg} !== {2'b11, 8'h00}) begin
            n_fail++; $display("FAIL add_refetch: got %b%b/%h expected 11/00", a_gate_pc, a_ld_mar, a_ld_reg);
        end
    endtask

    task automatic test_branch();
        obs_t e;
        do_reset();
        start(16'h0405, 3'b010);
        skip(6);
        n_chk++;
        if (obs_a() !== '0) begin n_fail++; $display("FAIL br_taken_br: got %h expected 0", obs_a()); end
        tick();
        e = '0; e.addr1mux = 1; e.addr2mux = 2'b01; e.pcmux = 2'b01; e.ld_pc = 1;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL br_take: got %h expected %h", obs_a(), e); end
        do_reset();
        start(16'h0405, 3'b100);
        skip(6);
        n_chk++;
        if (a_ld_pc !== 1'b0 || obs_a() !== '0) begin n_fail++; $display("FAIL br_nt_br: got %h expected 0", obs_a()); end
        tick();
        e = '0; e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL br_nt_fetch: got %h expected %h", obs_a(), e); end
    endtask

    task automatic test_jsr();
        obs_t e;
        do_reset();
        start(16'h4800, 3'b000);
        skip(6);
        e = '0; e.gate_pc = 1; e.ld_reg = 8'h80;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL jsr_save: got %h expected %h", obs_a(), e); end
        tick();
        e = '0; e.ld_pc = 1; e.pcmux = 2'b01; e.addr1mux = 1; e.addr2mux = 2'b11;
        n_chk++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL jsr_jump: got %h expected %h", obs_a(), e); end
    endtask

    task automatic test_store_wait();
        int nw, first, last;
        bit found;
        do_reset();
        start(16'h7642, 3'b000);
        nw = 0; first = -1; last = -1;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) tick();
            if (b_mem_wr) begin nw++; if (first < 0) first = k; last = k; end
            if (k == 9) begin
                n_chk++;
                if ({b_mio_en, b_ld_mdr, b_gate_alu, b_alu} !== 5'b11111) begin
                    n_fail++; $display("FAIL st_data: got %b expected 11111", {b_mio_en, b_ld_mdr, b_gate_alu, b_alu});
                end
            end
        end
        n_chk++;
        if (nw !== 5 || first !== 10 || last !== 14) begin
            n_fail++; $display("FAIL st_wait_len: got n=%0d first=%0d last=%0d expected 5/10/14", nw, first, last);
        end
        do_reset();
        start(16'h7642, 3'b000);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (b_mem_wr) found = 1;
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL st_wait_timeout: got no mem_wr expected mem_wr within 30 cycles"); end
        tick();
        n_chk++;
        if (b_mem_wr !== 1'b1) begin n_fail++; $display("FAIL st_wait2: got mem_wr=%b expected 1", b_mem_wr); end
        reset = 1'b1;
        tick();
        n_chk++;
        if (obs_b() !== '0) begin n_fail++; $display("FAIL st_reset: got %h expected 0", obs_b()); end
        reset = 1'b0;
        tick();
        n_chk++;
        if (obs_b() !== '0) begin n_fail++; $display("FAIL st_halted: got %h expected 0", obs_b()); end
    endtask

    task automatic test_illegal();
        int np, at, bad_reg;
        do_reset();
        start(16'h1E01, 3'b000);
        np = 0; at = -1; bad_reg = 0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            if (b_illegal) begin np++; at = k; end
            if (b_ld_reg !== 4'h0) bad_reg++;
        end
        n_chk++;
        if (np !== 1 || at !== 8 || bad_reg !== 0) begin
            n_fail++; $display("FAIL dr_range: got pulses=%0d at=%0d regloads=%0d expected 1/8/0", np, at, bad_reg);
        end
        do_reset();
        start(16'hF000, 3'b000);
        np = 0; at = -1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            if (b_illegal) begin np++; at = k; end
            if (k == 8) begin
                n_chk++;
                if ({b_gate_pc, b_ld_mar, b_ld_pc} !== 3'b111) begin
                    n_fail++; $display("FAIL ill_refetch: got %b expected 111", {b_gate_pc, b_ld_mar, b_ld_pc});
                end
            end
        end
        n_chk++;
        if (np !== 1 || at !== 7) begin n_fail++; $display("FAIL ill_op: got pulses=%0d at=%0d expected 1/7", np, at); end
    endtask

    task automatic test_pause();
        do_reset();
        start(16'hD000, 3'b000);
        skip(6);
        n_chk++;
        if (a_ld_led !== 1'b1) begin n_fail++; $display("FAIL pause1: got ld_led=%b expected 1", a_ld_led); end
        skip(2);
        n_chk++;
        if ({a_ld_led, a_gate_pc} !== 2'b10) begin n_fail++; $display("FAIL pause1_hold: got %b expected 10", {a_ld_led, a_gate_pc}); end
        continue_i = 1'b1;
        skip(2);
        n_chk++;
        if ({a_ld_led, a_gate_pc} !== 2'b10) begin n_fail++; $display("FAIL pause2_hold: got %b expected 10", {a_ld_led, a_gate_pc}); end
        continue_i = 1'b0;
        tick();
        n_chk++;
        if ({a_ld_led, a_gate_pc, a_ld_mar} !== 3'b011) begin
            n_fail++; $display("FAIL pause_exit: got %b expected 011", {a_ld_led, a_gate_pc, a_ld_mar});
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [15];
        logic [15:0] iv;
        logic [2:0] nv;
        obs_t got;
        bit sel;
        ops = '{4'h0, 4'h1, 4'h5, 4'h9, 4'hC, 4'h4, 4'h6, 4'h7,
                4'h2, 4'h3, 4'h8, 4'hA, 4'hB, 4'hE, 4'hF};
        for (int it = 0; it < 60; it++) begin
            sel = it[0];
            iv  = {ops[$urandom_range(0, 14)], 12'($urandom)};
            nv  = 3'($urandom);
            model(iv, nv, sel ? 5 : 3, sel ? 4 : 8);
            do_reset();
            start(iv, nv);
            for (int c = 0; c < exp_q.size(); c++) begin
                if (c > 0) tick();
                got = sel ? obs_b() : obs_a();
                n_chk++;
                if (got !== exp_q[c]) begin
                    n_fail++;
                    $display("FAIL rand inst=%0d ir=%h nzp=%b cyc=%0d: got %h expected %h",
                             sel, iv, nv, c, got, exp_q[c]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; run_i = 1'b0; continue_i = 1'b0; ir = '0; nzp = '0;
        test_reset();
        test_fetch_add();
        test_branch();
        test_jsr();
        test_store_wait();
        test_illegal();
        test_pause();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
